perf_counter_bank: RTL and testbench

Parametrised performance-counter bank for the single-cycle MIPS core. It counts executed cycles up to and including the halt instruction. It also counts NUM_EVENTS per-cycle event strobes, such as jump/jr, conditional branch and branch-taken. A snapshot/readout port lets the board display logic read a stable copy of any counter through one registered mux. It sits beside the datapath and observes control signals only; it never stalls the core.

---
 rtl/perf_pkg.sv | 20 ++
 rtl/perf_counter_bank_if.sv | 30 +++
 rtl/perf_counter.sv | 46 ++++
 rtl/perf_counter_bank.sv | 113 +++++++++++
 tb/tb_perf_counter_bank.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter bank.
// Holds the FSM state enum, channel indices and the read-select width helper.
package perf_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    localparam int unsigned CH_CYCLES = 0;
    localparam int unsigned CH_JUMP   = 1;
    localparam int unsigned CH_BRANCH = 2;
    localparam int unsigned CH_TAKEN  = 3;

    // Select width covering channel 0 (cycles) plus every event channel.
    function automatic int unsigned sel_w(input int unsigned num_events);
        return (num_events < 1) ? 1 : $clog2(num_events + 1);
    endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Control/readout bundle between the core-side observer and the counter bank.
// master drives strobes and the read select; slave returns the read data.
interface perf_counter_bank_if
    import perf_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_EVENTS = 3
);
    localparam int unsigned SELW = sel_w(NUM_EVENTS);

    logic                  halt;
    logic [NUM_EVENTS-1:0] evt;
    logic                  clr;
    logic                  snap;
    logic [SELW-1:0]       rd_sel;
    logic [WIDTH-1:0]      rd_data;
    logic                  rd_ovf;
    logic                  halted;

    modport master (
        output halt, evt, clr, snap, rd_sel,
        input  rd_data, rd_ovf, halted
    );

    modport slave (
        input  halt, evt, clr, snap, rd_sel,
        output rd_data, rd_ovf, halted
    );

endinterface

// File: rtl/perf_counter.sv
// Single live counter with sticky overflow; wraps or saturates at the top value.
module perf_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (cnt_q == {WIDTH{1'b1}}) begin
                ovf_d = 1'b1;
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle/event counter bank for the single-cycle core: run/halt FSM, per-channel
// increment qualification, snapshot shadows and a registered read mux.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_EVENTS = 3,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    perf_counter_bank_if.slave  bus
);

    localparam int unsigned NCH  = NUM_EVENTS + 1;
    localparam int unsigned SELW = sel_w(NUM_EVENTS);

    state_e state_q, state_d;
    logic   halted_q, halted_d;
    logic   run_c;
    logic   inc_c [NCH];

    logic [WIDTH-1:0] live_cnt [NCH];
    logic             live_ovf [NCH];
    logic [WIDTH-1:0] shadow_cnt_q [NCH];
    logic [WIDTH-1:0] shadow_cnt_d [NCH];
    logic             shadow_ovf_q [NCH];
    logic             shadow_ovf_d [NCH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_ovf_q, rd_ovf_d;

    // Run/halt FSM; the halt-entry cycle still counts as a RUN cycle.
    always_comb begin
        state_d  = state_q;
        if (bus.clr) begin
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN:    if (bus.halt) state_d = ST_HALTED;
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_RUN;
            endcase
        end
        halted_d = (state_d == ST_HALTED);
        run_c    = (state_q == ST_RUN) && !bus.clr;
    end

    always_comb begin
        for (int i = 0; i < int'(NCH); i++) inc_c[i] = 1'b0;
        inc_c[CH_CYCLES] = run_c;
        for (int i = 1; i < int'(NCH); i++) inc_c[i] = run_c && bus.evt[i-1];
    end

    for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
        perf_counter #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (bus.clr),
            .inc (inc_c[g]),
            .cnt (live_cnt[g]),
            .ovf (live_ovf[g])
        );
    end

    // Shadows capture pre-update live values, so a same-cycle clr is not seen.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            shadow_cnt_d[i] = bus.snap ? live_cnt[i] : shadow_cnt_q[i];
            shadow_ovf_d[i] = bus.snap ? live_ovf[i] : shadow_ovf_q[i];
        end
    end

    always_comb begin
        rd_data_d = '0;
        rd_ovf_d  = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (bus.rd_sel == SELW'(i)) begin
                rd_data_d = shadow_cnt_q[i];
                rd_ovf_d  = shadow_ovf_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            halted_q  <= 1'b0;
            rd_data_q <= '0;
            rd_ovf_q  <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                shadow_cnt_q[i] <= '0;
                shadow_ovf_q[i] <= 1'b0;
            end
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            rd_data_q <= rd_data_d;
            rd_ovf_q  <= rd_ovf_d;
            for (int i = 0; i < int'(NCH); i++) begin
                shadow_cnt_q[i] <= shadow_cnt_d[i];
                shadow_ovf_q[i] <= shadow_ovf_d[i];
            end
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_ovf  = rd_ovf_q;
    assign bus.halted  = halted_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: main, wrap, saturate and 4-event instances
// share clk/rst; expected reads go through a scoreboard queue.
module tb_perf_counter_bank;
    import perf_pkg::*;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        ovf;
    } exp_t;
    exp_t sb[$];

    perf_counter_bank_if #(.WIDTH(32), .NUM_EVENTS(3)) bif_main ();
    perf_counter_bank_if #(.WIDTH(4),  .NUM_EVENTS(3)) bif_wrap ();
    perf_counter_bank_if #(.WIDTH(4),  .NUM_EVENTS(3)) bif_sat  ();
    perf_counter_bank_if #(.WIDTH(32), .NUM_EVENTS(4)) bif_wide ();

    perf_counter_bank #(.WIDTH(32), .NUM_EVENTS(3), .SATURATE(1'b0)) u_main (.clk(clk), .rst(rst), .bus(bif_main));
    perf_counter_bank #(.WIDTH(4),  .NUM_EVENTS(3), .SATURATE(1'b0)) u_wrap (.clk(clk), .rst(rst), .bus(bif_wrap));
    perf_counter_bank #(.WIDTH(4),  .NUM_EVENTS(3), .SATURATE(1'b1)) u_sat  (.clk(clk), .rst(rst), .bus(bif_sat));
    perf_counter_bank #(.WIDTH(32), .NUM_EVENTS(4), .SATURATE(1'b0)) u_wide (.clk(clk), .rst(rst), .bus(bif_wide));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int which, input int sel);
        case (which)
            0:       bif_main.rd_sel = 2'(sel);
            1:       bif_wrap.rd_sel = 2'(sel);
            2:       bif_sat.rd_sel  = 2'(sel);
            default: bif_wide.rd_sel = 3'(sel);
        endcase
    endtask

    function automatic logic [32:0] get_rd(input int which);
        case (which)
            0:       return {bif_main.rd_ovf, bif_main.rd_data};
            1:       return {bif_wrap.rd_ovf, 28'b0, bif_wrap.rd_data};
            2:       return {bif_sat.rd_ovf, 28'b0, bif_sat.rd_data};
            default: return {bif_wide.rd_ovf, bif_wide.rd_data};
        endcase
    endfunction

    task automatic pop_cmp(input int which);
        exp_t        e;
        logic [32:0] o;
        e = sb.pop_front();
        o = get_rd(which);
        checks++;
        assert (o[31:0] === e.data) else begin
            failures++;
            $error("FAIL %s rd_data observed=%0d expected=%0d", e.tag, o[31:0], e.data);
        end
        checks++;
        assert (o[32] === e.ovf) else begin
            failures++;
            $error("FAIL %s rd_ovf observed=%0b expected=%0b", e.tag, o[32], e.ovf);
        end
    endtask

    // Select a channel, let the registered mux update, then compare.
    task automatic read_chk(input int which, input int sel, input logic [31:0] ed,
                            input logic eo, input string tag);
        exp_t e;
        set_sel(which, sel);
        e.tag  = tag;
        e.data = ed;
        e.ovf  = eo;
        sb.push_back(e);
        tick();
        pop_cmp(which);
    endtask

    // Compare current outputs without advancing the clock.
    task automatic now_chk(input int which, input logic [31:0] ed, input logic eo, input string tag);
        exp_t e;
        e.tag  = tag;
        e.data = ed;
        e.ovf  = eo;
        sb.push_back(e);
        pop_cmp(which);
    endtask

    task automatic halted_chk(input logic obs, input logic exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s halted observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bif_main.halt = 0; bif_main.evt = '0; bif_main.clr = 0; bif_main.snap = 0; bif_main.rd_sel = '0;
        bif_wrap.halt = 0; bif_wrap.evt = '0; bif_wrap.clr = 0; bif_wrap.snap = 0; bif_wrap.rd_sel = '0;
        bif_sat.halt  = 0; bif_sat.evt  = '0; bif_sat.clr  = 0; bif_sat.snap  = 0; bif_sat.rd_sel  = '0;
        bif_wide.halt = 0; bif_wide.evt = '0; bif_wide.clr = 0; bif_wide.snap = 0; bif_wide.rd_sel = '0;

        // Reset values
        tick(); tick();
        rst = 1'b0;
        halted_chk(bif_main.halted, 1'b0, "reset_halted");
        now_chk(0, 32'd0, 1'b0, "reset_rd");
        for (int c = 0; c < 4; c++) read_chk(0, c, 32'd0, 1'b0, "reset_shadow");
        rst = 1'b1; tick(); rst = 1'b0;

        // Run then halt: 10 run cycles + halt-entry cycle = 11
        repeat (10) tick();
        bif_main.halt = 1'b1;
        repeat (5) tick();
        bif_main.halt = 1'b0;
        bif_main.snap = 1'b1; tick(); bif_main.snap = 1'b0;
        read_chk(0, CH_CYCLES, 32'd11, 1'b0, "run_halt_cycles");
        halted_chk(bif_main.halted, 1'b1, "run_halt_halted");
        read_chk(0, CH_JUMP, 32'd0, 1'b0, "run_halt_no_evt");
        repeat (3) tick();
        bif_main.halt = 1'b1; tick(); bif_main.halt = 1'b0;
        bif_main.snap = 1'b1; tick(); bif_main.snap = 1'b0;
        read_chk(0, CH_CYCLES, 32'd11, 1'b0, "halted_frozen");

        // Snap and clr in the same cycle
        bif_main.clr = 1'b1; tick(); bif_main.clr = 1'b0;
        halted_chk(bif_main.halted, 1'b0, "clr_leaves_halt");
        repeat (7) tick();
        bif_main.snap = 1'b1; bif_main.clr = 1'b1; tick();
        bif_main.snap = 1'b0; bif_main.clr = 1'b0;
        read_chk(0, CH_CYCLES, 32'd7, 1'b0, "snap_clr_preclear");
        halted_chk(bif_main.halted, 1'b0, "snap_clr_run");
        repeat (2) tick();
        bif_main.snap = 1'b1; tick(); bif_main.snap = 1'b0;
        read_chk(0, CH_CYCLES, 32'd3, 1'b0, "clr_restart_count");

        // Event counting with overlapping strobes
        rst = 1'b1; tick(); rst = 1'b0;
        bif_main.evt = 3'b011; repeat (4) tick();
        bif_main.evt = 3'b100; repeat (2) tick();
        bif_main.evt = 3'b000;
        bif_main.snap = 1'b1; tick(); bif_main.snap = 1'b0;
        read_chk(0, CH_JUMP,   32'd4, 1'b0, "evt_jump");
        read_chk(0, CH_BRANCH, 32'd4, 1'b0, "evt_branch");
        read_chk(0, CH_TAKEN,  32'd2, 1'b0, "evt_taken");
        read_chk(0, CH_CYCLES, 32'd6, 1'b0, "evt_cycles");
        bif_main.halt = 1'b1; tick(); bif_main.halt = 1'b0;
        halted_chk(bif_main.halted, 1'b1, "evt_halted");
        bif_main.evt = 3'b111; tick(); bif_main.evt = 3'b000;
        bif_main.snap = 1'b1; tick(); bif_main.snap = 1'b0;
        read_chk(0, CH_JUMP,   32'd4, 1'b0, "halted_evt_jump");
        read_chk(0, CH_BRANCH, 32'd4, 1'b0, "halted_evt_branch");
        read_chk(0, CH_TAKEN,  32'd2, 1'b0, "halted_evt_taken");

        // Reset precedence while HALTED with snap, clr and all events
        rst = 1'b1; bif_main.snap = 1'b1; bif_main.clr = 1'b1; bif_main.evt = 3'b111;
        tick();
        rst = 1'b0; bif_main.snap = 1'b0; bif_main.clr = 1'b0; bif_main.evt = 3'b000;
        halted_chk(bif_main.halted, 1'b0, "rst_halted");
        now_chk(0, 32'd0, 1'b0, "rst_rd_now");
        for (int c = 0; c < 4; c++) read_chk(0, c, 32'd0, 1'b0, "rst_shadow");
        bif_main.snap = 1'b1; tick(); bif_main.snap = 1'b0;
        read_chk(0, CH_CYCLES, 32'd4, 1'b0, "rst_resume");

        // Wrap versus saturate on a 4-bit counter
        rst = 1'b1; tick(); rst = 1'b0;
        bif_wrap.evt = 3'b001; bif_sat.evt = 3'b001;
        repeat (15) tick();
        bif_wrap.evt = 3'b000; bif_sat.evt = 3'b000;
        bif_wrap.snap = 1'b1; bif_sat.snap = 1'b1; tick(); bif_wrap.snap = 1'b0; bif_sat.snap = 1'b0;
        read_chk(1, CH_JUMP, 32'd15, 1'b0, "wrap_at_max");
        read_chk(2, CH_JUMP, 32'd15, 1'b0, "sat_at_max");
        bif_wrap.evt = 3'b001; bif_sat.evt = 3'b001;
        repeat (2) tick();
        bif_wrap.evt = 3'b000; bif_sat.evt = 3'b000;
        bif_wrap.snap = 1'b1; bif_sat.snap = 1'b1; tick(); bif_wrap.snap = 1'b0; bif_sat.snap = 1'b0;
        read_chk(1, CH_JUMP, 32'd1,  1'b1, "wrap_17");
        read_chk(2, CH_JUMP, 32'd15, 1'b1, "sat_17");
        bif_wrap.clr = 1'b1; bif_sat.clr = 1'b1; tick(); bif_wrap.clr = 1'b0; bif_sat.clr = 1'b0;
        bif_wrap.snap = 1'b1; bif_sat.snap = 1'b1; tick(); bif_wrap.snap = 1'b0; bif_sat.snap = 1'b0;
        read_chk(1, CH_JUMP, 32'd0, 1'b0, "wrap_clr_ovf");
        read_chk(2, CH_JUMP, 32'd0, 1'b0, "sat_clr_ovf");

        // Out-of-range select with NUM_EVENTS=4
        bif_wide.evt = 4'b1000; repeat (3) tick(); bif_wide.evt = 4'b0000;
        bif_wide.snap = 1'b1; tick(); bif_wide.snap = 1'b0;
        read_chk(3, 4, 32'd3, 1'b0, "wide_ch4");
        read_chk(3, 7, 32'd0, 1'b0, "wide_sel7");
        read_chk(3, 4, 32'd3, 1'b0, "wide_ch4_again");
        read_chk(3, 5, 32'd0, 1'b0, "wide_sel5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
